cache_fill_fsm: RTL



---
 rtl/cache_defs.sv | 16 +
 rtl/fill_counter.sv | 29 ++
 rtl/cache_fill_fsm.sv | 121 ++++++++++++
 3 files changed

// File: rtl/cache_defs.sv
// Shared encodings for the cache miss/fill controller: cacheop codes, FSM states, block geometry.
package cache_defs;

  localparam int unsigned WORDS_PER_BLOCK = 8;

  localparam logic [1:0] CACHEOP_READ = 2'b00;
  localparam logic [1:0] CACHEOP_FILL = 2'b01;
  localparam logic [1:0] CACHEOP_TAG  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_TAG  = 2'd2
  } fill_state_e;

endpackage

// File: rtl/fill_counter.sv
// Word counter for a block fill: async reset, synchronous clear, enable, saturates at MAX.
module fill_counter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MAX   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != MAX_CNT)) begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/cache_fill_fsm.sv
// Miss arbiter and block-fill sequencer feeding the I- and D-caches from pipelined main memory.
module cache_fill_fsm
  import cache_defs::*;
#(
  parameter int unsigned WORDS_PER_BLOCK = cache_defs::WORDS_PER_BLOCK
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_miss,
  input  logic [15:0] i_miss_addr,
  input  logic        d_miss,
  input  logic [15:0] d_miss_addr,
  output logic        mem_en,
  output logic [15:0] mem_addr,
  input  logic        mem_data_valid,
  input  logic [15:0] mem_data,
  output logic [1:0]  i_cacheop,
  output logic [1:0]  d_cacheop,
  output logic [15:0] fill_addr,
  output logic [15:0] fill_data,
  output logic        fill_target,
  output logic        fsm_busy
);

  localparam logic [3:0] CNT_MAX  = 4'(WORDS_PER_BLOCK);
  localparam logic [3:0] CNT_LAST = 4'(WORDS_PER_BLOCK - 1);

  fill_state_e state_q, state_d;
  logic [15:0] base_q, base_d;
  logic        fill_target_q, fill_target_d;
  logic [3:0]  req_cnt, ret_cnt;
  logic [1:0]  op;
  logic        in_fill;

  assign in_fill = (state_q == ST_FILL);

  // Request and return streams overlap, so each side keeps its own count.
  fill_counter #(
    .WIDTH (4),
    .MAX   (WORDS_PER_BLOCK)
  ) u_req_cnt (
    .clk (clk),
    .rst (rst),
    .en  (in_fill),
    .clr (!in_fill),
    .cnt (req_cnt)
  );

  fill_counter #(
    .WIDTH (4),
    .MAX   (WORDS_PER_BLOCK)
  ) u_ret_cnt (
    .clk (clk),
    .rst (rst),
    .en  (in_fill && mem_data_valid),
    .clr (!in_fill),
    .cnt (ret_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      base_q        <= '0;
      fill_target_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      fill_target_q <= fill_target_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    fill_target_d = fill_target_q;
    mem_en        = 1'b0;
    mem_addr      = '0;
    op            = CACHEOP_READ;
    fill_addr     = '0;
    fill_data     = '0;
    unique case (state_q)
      ST_IDLE: begin
        // D-side miss belongs to the older instruction, so it wins a tie.
        if (d_miss) begin
          base_d        = {d_miss_addr[15:4], 4'b0000};
          fill_target_d = 1'b1;
          state_d       = ST_FILL;
        end else if (i_miss) begin
          base_d        = {i_miss_addr[15:4], 4'b0000};
          fill_target_d = 1'b0;
          state_d       = ST_FILL;
        end
      end
      ST_FILL: begin
        if (req_cnt != CNT_MAX) begin
          mem_en   = 1'b1;
          mem_addr = base_q + {11'b0, req_cnt, 1'b0};
        end
        if (mem_data_valid && (ret_cnt != CNT_MAX)) begin
          op        = CACHEOP_FILL;
          fill_addr = base_q | {11'b0, ret_cnt, 1'b0};
          fill_data = mem_data;
          if (ret_cnt == CNT_LAST) state_d = ST_TAG;
        end
      end
      ST_TAG: begin
        // Tag goes in last so the block only becomes visible once all words are written.
        op        = CACHEOP_TAG;
        fill_addr = base_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign i_cacheop   = fill_target_q ? CACHEOP_READ : op;
  assign d_cacheop   = fill_target_q ? op : CACHEOP_READ;
  assign fill_target = fill_target_q;
  assign fsm_busy    = (state_q != ST_IDLE);

endmodule
